// File: rtl/vga_sync_gen_if.sv
// Timing outputs of vga_sync_gen bundled for the video path.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, H/V scan counters and registered sync decode.
// Optional 8-bit frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned TICK_DIV  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    vga_sync_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || TICK_DIV < 1) begin : g_param_check
        $error("vga_sync_gen: totals must be <= 1024 and TICK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       pixel_x_q, pixel_x_d;
    logic [9:0]       pixel_y_q, pixel_y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             at_origin_q, at_origin_d;
    logic             p_tick;
    logic             at_origin;

    assign p_tick    = (div_cnt_q == DIV_W'(TICK_DIV - 1));
    assign at_origin = (pixel_x_q == '0) && (pixel_y_q == '0);

    always_comb begin
        div_cnt_d = p_tick ? '0 : div_cnt_q + 1'b1;
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (p_tick) begin
            if (pixel_x_q == X_LAST) begin
                pixel_x_d = '0;
                pixel_y_d = (pixel_y_q == Y_LAST) ? '0 : pixel_y_q + 10'd1;
            end else begin
                pixel_x_d = pixel_x_q + 10'd1;
            end
        end
    end

    // at_origin_q resets to 1 so the (0,0) entered from reset does not count as a new frame
    always_comb begin
        hsync_d       = !((pixel_x_q >= HS_FIRST) && (pixel_x_q <= HS_LAST));
        vsync_d       = !((pixel_y_q >= VS_FIRST) && (pixel_y_q <= VS_LAST));
        video_on_d    = (pixel_x_q < H_VIS) && (pixel_y_q < V_VIS);
        frame_start_d = at_origin && !at_origin_q;
        at_origin_d   = at_origin;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            at_origin_q   <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            at_origin_q   <= at_origin_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_wrap;

    assign frame_wrap = p_tick && (pixel_x_q == X_LAST) && (pixel_y_q == Y_LAST);

    always_comb begin
        frame_cnt_d = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.p_tick      = p_tick;
    assign vga.pixel_x     = pixel_x_q;
    assign vga.pixel_y     = pixel_y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a reduced 15x10 frame (TICK_DIV=4 and TICK_DIV=1 instances).
// frame_cnt checks are compiled in when VGA_FRAME_CNT_EN is defined.
module tb_vga_sync_gen;
    localparam int unsigned HT      = 15;   // 8 + 2 + 3 + 2
    localparam int unsigned VT      = 10;   // 6 + 1 + 2 + 1
    localparam int unsigned FRAME_A = HT * VT * 4;
    localparam int unsigned FRAME_B = HT * VT;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen_if ia ();
    vga_sync_gen_if ib ();

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(4)
    ) u_dut_a (.clk(clk), .reset_n(reset_n), .vga(ia));

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(1)
    ) u_dut_b (.clk(clk), .reset_n(reset_n), .vga(ib));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned since_rel;

    // clk edges since the last reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) since_rel <= 0;
        else          since_rel <= since_rel + 1;
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // waits for pixel_x of instance A to change to x; n = negedges elapsed
    task automatic wait_x(input int unsigned x, output bit found, output int unsigned n);
        logic [9:0] prev;
        prev  = ia.pixel_x;
        found = 1'b0;
        n     = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (ia.pixel_x == 10'(x) && prev != 10'(x)) found = 1'b1;
            prev = ia.pixel_x;
        end
    endtask

    task automatic step_to(input int unsigned target);
        while (since_rel < target) @(negedge clk);
    endtask

    initial begin
        bit          found;
        int unsigned n, lo, vs_low, vs_bad, vis;
        logic [9:0]  prev_y;
        logic        exp_vs;

        // reset held for 10 clks
        reset_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_val("rst_p_tick", ia.p_tick, 0);
        end
        check_val("rst_pixel_x", ia.pixel_x, 0);
        check_val("rst_pixel_y", ia.pixel_y, 0);
        check_val("rst_hsync", ia.hsync, 1);
        check_val("rst_vsync", ia.vsync, 1);
        check_val("rst_video_on", ia.video_on, 0);
        check_val("rst_frame_start", ia.frame_start, 0);

        reset_n = 1'b1;
        @(negedge clk);
        check_val("rel_video_on", ia.video_on, 1);
        check_val("rel_hsync", ia.hsync, 1);
        check_val("rel_vsync", ia.vsync, 1);
        check_val("rel_frame_start", ia.frame_start, 0);
        check_val("rel_p_tick_c1", ia.p_tick, 0);
        repeat (2) @(negedge clk);
        // p_tick is high in the 4th clk period; the counter steps on the 4th edge
        check_val("rel_p_tick_c4", ia.p_tick, 1);
        check_val("rel_x_before_tick", ia.pixel_x, 0);
        @(negedge clk);
        check_val("rel_x_after_tick", ia.pixel_x, 1);
        check_val("rel_p_tick_c5", ia.p_tick, 0);

        // horizontal: video_on drops 1 clk after x=8, hsync drops 1 clk after x=10
        wait_x(8, found, n);
        check_val("h_found_x8", found, 1);
        check_val("h_video_on_at_x8", ia.video_on, 1);
        @(negedge clk);
        check_val("h_video_on_x8_lag", ia.video_on, 0);
        wait_x(10, found, n);
        check_val("h_found_x10", found, 1);
        check_val("h_hsync_at_x10", ia.hsync, 1);
        @(negedge clk);
        check_val("h_hsync_x10_lag", ia.hsync, 0);
        lo = 0;
        while (ia.hsync == 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check_val("h_hsync_low_clks", lo, 12);
        wait_x(0, found, n);
        check_val("h_found_x0", found, 1);
        wait_x(0, found, n);
        check_val("h_line_clks", n, 60);

        // frames: period, vsync window (lags pixel_y by 1 clk), visible ticks
        n = 0;
        while (!ia.frame_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("v_fs_seen", ia.frame_start, 1);
        check_val("v_fs_pixel_x", ia.pixel_x, 0);
        check_val("v_fs_pixel_y", ia.pixel_y, 0);
        for (int f = 0; f < 2; f++) begin
            n = 0; vs_low = 0; vs_bad = 0; vis = 0;
            prev_y = ia.pixel_y;
            do begin
                @(negedge clk);
                n++;
                exp_vs = !(prev_y >= 10'd7 && prev_y <= 10'd8);
                if (ia.vsync !== exp_vs) vs_bad++;
                if (ia.vsync == 1'b0) vs_low++;
                if (ia.p_tick && ia.video_on) vis++;
                prev_y = ia.pixel_y;
            end while (!ia.frame_start && n < 2000);
            check_val($sformatf("v_frame%0d_clks", f), n, FRAME_A);
            check_val($sformatf("v_frame%0d_vsync_low", f), vs_low, 120);
            check_val($sformatf("v_frame%0d_vsync_align", f), vs_bad, 0);
            check_val($sformatf("v_frame%0d_visible", f), vis, 48);
        end

        // reset mid-frame at (11,4): hsync is low there
        n = 0;
        while (!(ia.pixel_x == 10'd11 && ia.pixel_y == 10'd4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_reached_x", ia.pixel_x, 11);
        check_val("mid_hsync_before", ia.hsync, 0);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_pixel_x", ia.pixel_x, 0);
        check_val("mid_pixel_y", ia.pixel_y, 0);
        check_val("mid_hsync", ia.hsync, 1);
        check_val("mid_vsync", ia.vsync, 1);
        check_val("mid_video_on", ia.video_on, 0);
        check_val("mid_frame_start", ia.frame_start, 0);
        check_val("mid_p_tick", ia.p_tick, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // TICK_DIV=1 instance: 15-clk lines, p_tick always high
        step_to(14);
        check_val("b_x_at_14", ib.pixel_x, 14);
        check_val("b_y_at_14", ib.pixel_y, 0);
        check_val("b_p_tick_14", ib.p_tick, 1);
        step_to(15);
        check_val("b_x_at_15", ib.pixel_x, 0);
        check_val("b_y_at_15", ib.pixel_y, 1);
        check_val("b_p_tick_15", ib.p_tick, 1);

        // first frame_start after release: wrap at edge 600, pulse registered one edge later
        while (!ia.frame_start && since_rel < 2000) @(negedge clk);
        check_val("mid_first_fs_clk", since_rel, FRAME_A + 1);

`ifdef VGA_FRAME_CNT_EN
        step_to(255 * FRAME_B + 5);
        check_val("fc_255", ib.frame_cnt, 255);
        step_to(256 * FRAME_B + 5);
        check_val("fc_wrap_0", ib.frame_cnt, 0);
        step_to(257 * FRAME_B + 5);
        check_val("fc_257", ib.frame_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for the video path. Divides the system clock down to a pixel tick and scans a horizontal/vertical counter pair over the full 800×525 frame. Produces `hsync`, `vsync`, `video_on` and the current pixel coordinates. `video_on` drives the color-gating mux that blanks RGB outside the visible area, and `pixel_x`/`pixel_y` drive the pixel/text generators.

## Interface
Parameters:
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_DISPLAY`, 480: visible lines
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `TICK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); legal range ≥1

Ports:
- `clk` input 1: system clock; the only clock
- `reset_n` input 1: asynchronous, active-low reset
- `p_tick` output 1: pixel-rate enable, high for one clk per pixel period
- `pixel_x` output 10: horizontal counter, 0..H_TOTAL-1
- `pixel_y` output 10: vertical counter, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, active-low
- `vsync` output 1: vertical sync, active-low
- `video_on` output 1: high inside the visible area
- `frame_start` output 1: one-clk pulse at the start of each frame
- `frame_cnt` output 8: frame counter; present only with `VGA_FRAME_CNT_EN`

## Operation
- Derived constants: `H_TOTAL` = sum of the four H parameters (800); `V_TOTAL` = sum of the four V parameters (525). Both totals must be ≤ 1024; elaboration fails otherwise.
- Divider:
  - `div_cnt` counts 0..TICK_DIV-1, wrapping every clk.
  - `p_tick` = (`div_cnt` == TICK_DIV-1), decoded combinationally from the register.
  - With TICK_DIV=1, `p_tick` is constantly 1 out of reset.
- Counters advance only on clk edges where `p_tick`=1:
  - `pixel_x` increments and wraps H_TOTAL-1 → 0.
  - On that wrap, `pixel_y` increments and wraps V_TOTAL-1 → 0.
  - Both wraps coincide on the same edge at (H_TOTAL-1, V_TOTAL-1).
- Decode, registered every clk from the current counters:
  - `hsync`=0 iff H_DISPLAY+H_FRONT ≤ `pixel_x` ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - `vsync`=0 iff V_DISPLAY+V_FRONT ≤ `pixel_y` ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - `video_on`=1 iff `pixel_x` < H_DISPLAY and `pixel_y` < V_DISPLAY.
  - `frame_start`=1 iff the counters are (0,0) and the previous clk's counters were not (0,0). It fires once per frame and not on every clk of pixel (0,0).
- Reset, asynchronous while `reset_n`=0:
  - `div_cnt`=0, `pixel_x`=0, `pixel_y`=0.
  - `hsync`=1, `vsync`=1, `video_on`=0, `frame_start`=0, `frame_cnt`=0.
  - Reset mid-frame aborts the scan immediately. No partial-frame state survives.
- Release from reset:
  - The first clk edge loads the decode of (0,0): `video_on`=1, syncs 1.
  - `frame_start` stays 0 for this post-reset (0,0); it first pulses at the next frame wrap.
  - The first `p_tick` occurs TICK_DIV clks after release.

## Timing
- `hsync`, `vsync`, `video_on` and `frame_start` lag `pixel_x`/`pixel_y` by exactly one clk. This matches the one-cycle registered pixel-generator latency downstream, so color and `video_on` reach the mux aligned.
- Line period: H_TOTAL×TICK_DIV clks = 3200.
- Frame period: H_TOTAL×V_TOTAL×TICK_DIV clks = 1,680,000.
- `hsync` low width: H_SYNC×TICK_DIV = 384 clks.
- `vsync` low width: V_SYNC×H_TOTAL×TICK_DIV = 6400 clks.
- All outputs are glitch-free, since every output except `p_tick` is a register.

## Configuration
- Macro: `VGA_FRAME_CNT_EN`.
- Defined:
  - Adds the `frame_cnt` port, an 8-bit register.
  - It increments on the clk edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), and wraps 255 → 0.
  - Reset value is 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset_n`=0 for 10 clks, with `p_tick` sampled high during reset being a failure. Required: `pixel_x`=0, `pixel_y`=0, `hsync`=1, `vsync`=1, `video_on`=0, `p_tick`=0. One clk after release, `video_on`=1. The first `p_tick` arrives 4 clks after release.
- Horizontal: run one line. Required:
  - Line length 3200 clks.
  - `hsync` falls 1 clk after `pixel_x` becomes 656 and stays low 384 clks.
  - `video_on` falls 1 clk after `pixel_x` becomes 640.
- Vertical/frame: run 2 frames. Required:
  - `vsync` low exactly while `pixel_y` = 490..491, delayed 1 clk, for 6400 clks.
  - `frame_start` pulses once per frame, 1,680,000 clks apart.
  - 307,200 `p_tick` cycles per frame have `video_on`=1.
- Reset mid-frame: assert `reset_n`=0 at `pixel_x`=700, `pixel_y`=300. Required: outputs take their reset values immediately, without waiting for a clk edge. After release, a full 1,680,000-clk frame follows before the first `frame_start`.
- TICK_DIV=1 build: `p_tick` is constantly 1 and the line period is 800 clks.
- `VGA_FRAME_CNT_EN` defined: run 257 frames. Required: `frame_cnt` wraps 255 → 0 and reads 1 after 257 wraps.
